// File: rtl/enemy_fire_sched.sv
// Enemy fire scheduler: every FIRE_INTERVAL cycles picks a pseudo-random start
// slot, scans for the first live enemy and requests a shot on the lowest free channel.
module enemy_fire_sched #(
  parameter int unsigned N_ENEMY       = 8,
  parameter int unsigned N_MISSILE     = 2,
  parameter int unsigned FIRE_INTERVAL = 250000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [N_ENEMY-1:0]         enemy_alive,
  input  logic [12*N_ENEMY-1:0]      enemy_xpos,
  input  logic [12*N_ENEMY-1:0]      enemy_ypos,
  input  logic [N_MISSILE-1:0]       missile_on,
  output logic [N_MISSILE-1:0]       fire,
  output logic [11:0]                fire_xpos,
  output logic [11:0]                fire_ypos,
  output logic [$clog2(N_ENEMY)-1:0] fire_enemy,
  output logic [15:0]                shots_fired
);
  localparam int unsigned IDX_W    = $clog2(N_ENEMY);
  localparam int unsigned CNT_W    = $clog2(FIRE_INTERVAL);
  localparam int unsigned CH_W     = (N_MISSILE > 1) ? $clog2(N_MISSILE) : 1;
  localparam int unsigned POS_W    = 12;
  localparam int unsigned HOLD_MAX = 3;

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_PICK  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]           state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [15:0]          lfsr, lfsr_n;
  logic [IDX_W-1:0]     start_idx, start_idx_n;
  logic [IDX_W-1:0]     step, step_n;
  logic [CH_W-1:0]      hold_ch, hold_ch_n;
  logic [1:0]           hold_cnt, hold_cnt_n;
  logic [N_MISSILE-1:0] fire_n;
  logic [POS_W-1:0]     fire_xpos_n, fire_ypos_n;
  logic [IDX_W-1:0]     fire_enemy_n;
  logic [15:0]          shots_fired_n;

  logic [IDX_W-1:0]     scan_idx;
  logic [POS_W-1:0]     xpos_arr [N_ENEMY];
  logic [POS_W-1:0]     ypos_arr [N_ENEMY];
  logic                 free_found;
  logic [CH_W-1:0]      free_ch;

  assign scan_idx = start_idx + step;
  assign lfsr_n   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_comb begin
    for (int i = 0; i < N_ENEMY; i++) begin
      xpos_arr[i] = enemy_xpos[POS_W*i +: POS_W];
      ypos_arr[i] = enemy_ypos[POS_W*i +: POS_W];
    end
  end

  // Lowest-index idle missile channel
  always_comb begin
    free_found = 1'b0;
    free_ch    = '0;
    for (int c = N_MISSILE - 1; c >= 0; c--) begin
      if (!missile_on[c]) begin
        free_found = 1'b1;
        free_ch    = CH_W'(c);
      end
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    start_idx_n   = start_idx;
    step_n        = step;
    hold_ch_n     = hold_ch;
    hold_cnt_n    = hold_cnt;
    fire_n        = fire;
    fire_xpos_n   = fire_xpos;
    fire_ypos_n   = fire_ypos;
    fire_enemy_n  = fire_enemy;
    shots_fired_n = shots_fired;
    if (!enable) begin
      state_n = S_WAIT;
      fire_n  = '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == CNT_W'(FIRE_INTERVAL - 1)) begin
            cnt_n   = '0;
            state_n = S_PICK;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_PICK: begin
          start_idx_n = lfsr[IDX_W-1:0];
          step_n      = '0;
          state_n     = S_SCAN;
        end
        S_SCAN: begin
          if (enemy_alive[scan_idx]) begin
            fire_enemy_n = scan_idx;
            fire_xpos_n  = xpos_arr[scan_idx];
            fire_ypos_n  = ypos_arr[scan_idx];
            state_n      = S_ISSUE;
          end else if (step == IDX_W'(N_ENEMY - 1)) begin
            state_n = S_WAIT;
          end else begin
            step_n = step + IDX_W'(1);
          end
        end
        S_ISSUE: begin
          if (free_found) begin
            fire_n        = N_MISSILE'(1) << free_ch;
            hold_ch_n     = free_ch;
            hold_cnt_n    = '0;
            shots_fired_n = shots_fired + 16'd1;
            state_n       = S_HOLD;
          end else begin
            state_n = S_WAIT;
          end
        end
        S_HOLD: begin
          // Release on channel acknowledge or after four cycles high
          if (missile_on[hold_ch] || hold_cnt == 2'(HOLD_MAX)) begin
            fire_n  = '0;
            state_n = S_WAIT;
          end else begin
            hold_cnt_n = hold_cnt + 2'd1;
          end
        end
        default: begin
          fire_n  = '0;
          state_n = S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= S_WAIT;
      cnt         <= '0;
      lfsr        <= LFSR_SEED;
      start_idx   <= '0;
      step        <= '0;
      hold_ch     <= '0;
      hold_cnt    <= '0;
      fire        <= '0;
      fire_xpos   <= '0;
      fire_ypos   <= '0;
      fire_enemy  <= '0;
      shots_fired <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lfsr        <= lfsr_n;
      start_idx   <= start_idx_n;
      step        <= step_n;
      hold_ch     <= hold_ch_n;
      hold_cnt    <= hold_cnt_n;
      fire        <= fire_n;
      fire_xpos   <= fire_xpos_n;
      fire_ypos   <= fire_ypos_n;
      fire_enemy  <= fire_enemy_n;
      shots_fired <= shots_fired_n;
    end
  end

endmodule
